// File: rtl/fadd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fadd_pipe
// Brief    : Four-stage pipelined IEEE-754 binary32/binary64 adder/subtractor
//            with RNE rounding, flush-to-zero and valid/ready handshake.
// Revision : 1.0
// ============================================================================
module fadd_pipe #(
    parameter int N     = 32,
    parameter int EXP_W = (N == 32) ? 8 : 11,
    parameter int MAN_W = (N == 32) ? 23 : 52
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic [2:0]   flags
);
    generate
        if (N != 32 && N != 64) begin : g_bad_n
            $error("fadd_pipe: N must be 32 or 64");
        end
    endgenerate

    // Working mantissa: hidden bit, stored fraction, guard, round, sticky.
    localparam int               c_mw   = MAN_W + 4;
    localparam logic [EXP_W-1:0] c_dmax = EXP_W'(c_mw - 1);
    localparam logic [EXP_W:0]   c_e1   = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [N-1:0]     c_qnan = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic w_stall;
    assign w_stall  = out_valid && !out_ready;
    assign in_ready = !w_stall;

    // ---------------- stage 1: unpack, classify, order ----------------
    logic             w_sa, w_sb, w_za, w_zb, w_ia, w_ib, w_na, w_nb, w_swap;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic             w_spec;
    logic [N-1:0]     w_sres;
    logic [2:0]       w_sflg;

    assign w_sa   = a[N-1];
    assign w_sb   = b[N-1] ^ sub;
    assign w_ea   = a[N-2:MAN_W];
    assign w_eb   = b[N-2:MAN_W];
    assign w_za   = (w_ea == '0);
    assign w_zb   = (w_eb == '0);
    assign w_ia   = (&w_ea) && (a[MAN_W-1:0] == '0);
    assign w_ib   = (&w_eb) && (b[MAN_W-1:0] == '0);
    assign w_na   = (&w_ea) && (a[MAN_W-1:0] != '0);
    assign w_nb   = (&w_eb) && (b[MAN_W-1:0] != '0);
    assign w_fa   = w_za ? '0 : a[MAN_W-1:0];
    assign w_fb   = w_zb ? '0 : b[MAN_W-1:0];
    assign w_swap = {w_eb, w_fb} > {w_ea, w_fa};

    always_comb begin
        w_spec = 1'b1;
        w_sres = '0;
        w_sflg = 3'b000;
        if (w_na || w_nb) begin
            w_sres = c_qnan;
        end else if (w_ia && w_ib) begin
            if (w_sa != w_sb) begin
                w_sres = c_qnan;
                w_sflg = 3'b100;
            end else begin
                w_sres = {w_sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
        end else if (w_ia) begin
            w_sres = {w_sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_ib) begin
            w_sres = {w_sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_za && w_zb) begin
            w_sres = {w_sa & w_sb, {(N-1){1'b0}}};
        end else if (w_za) begin
            w_sres = {w_sb, w_eb, b[MAN_W-1:0]};
        end else if (w_zb) begin
            w_sres = {w_sa, w_ea, a[MAN_W-1:0]};
        end else begin
            w_spec = 1'b0;
        end
    end

    logic             r1_v, r1_spec, r1_sign, r1_esub;
    logic [N-1:0]     r1_sres;
    logic [2:0]       r1_sflg;
    logic [EXP_W-1:0] r1_exp, r1_d;
    logic [MAN_W-1:0] r1_frac_l, r1_frac_s;

    // ---------------- stage 2: align smaller operand ----------------
    logic [2*c_mw-1:0] w_wide;
    logic [c_mw-1:0]   w_mal;

    assign w_wide = {1'b1, r1_frac_s, 3'b000, {c_mw{1'b0}}} >> r1_d;
    assign w_mal  = (r1_d >= c_dmax) ? {{(c_mw-1){1'b0}}, 1'b1}
                  : {w_wide[2*c_mw-1:c_mw+1], w_wide[c_mw] | (|w_wide[c_mw-1:0])};

    logic             r2_v, r2_spec, r2_sign, r2_esub;
    logic [N-1:0]     r2_sres;
    logic [2:0]       r2_sflg;
    logic [EXP_W-1:0] r2_exp;
    logic [c_mw-1:0]  r2_man_l, r2_man_s;

    // ---------------- stage 3: add/subtract and leading-zero count ----------------
    logic [c_mw:0]    w_sum;
    logic [EXP_W-1:0] w_lzc;

    assign w_sum = r2_esub ? ({1'b0, r2_man_l} - {1'b0, r2_man_s})
                           : ({1'b0, r2_man_l} + {1'b0, r2_man_s});

    always_comb begin
        w_lzc = EXP_W'(c_mw + 1);
        for (int i = 0; i <= c_mw; i++) begin
            if (w_sum[i]) w_lzc = EXP_W'(c_mw - i);
        end
    end

    logic             r3_v, r3_spec, r3_sign;
    logic [N-1:0]     r3_sres;
    logic [2:0]       r3_sflg;
    logic [EXP_W-1:0] r3_exp, r3_lzc;
    logic [c_mw:0]    r3_sum;

    // ---------------- stage 4: normalise, round, pack ----------------
    logic [c_mw-1:0]  w_m;
    logic [EXP_W:0]   w_e;
    logic             w_flush, w_rnd;
    logic [MAN_W+1:0] w_mr;
    logic [MAN_W-1:0] w_frac;
    logic [N-1:0]     w_res;
    logic [2:0]       w_flg;

    always_comb begin
        w_m     = r3_sum[c_mw-1:0];
        w_e     = {1'b0, r3_exp};
        w_flush = 1'b0;
        if (r3_sum[c_mw]) begin
            w_m = {r3_sum[c_mw:2], r3_sum[1] | r3_sum[0]};
            w_e = w_e + c_e1;
        end else if (r3_lzc > r3_exp) begin
            // Normalising would need an exponent below 1: result is subnormal.
            w_flush = 1'b1;
        end else begin
            w_m = r3_sum[c_mw-1:0] << (r3_lzc - 1'b1);
            w_e = w_e - {1'b0, r3_lzc} + c_e1;
        end
        w_rnd  = w_m[2] & (w_m[3] | w_m[1] | w_m[0]);
        w_mr   = {1'b0, w_m[c_mw-1:3]} + {{(MAN_W+1){1'b0}}, w_rnd};
        if (w_mr[MAN_W+1]) w_e = w_e + c_e1;
        w_frac = w_mr[MAN_W+1] ? w_mr[MAN_W:1] : w_mr[MAN_W-1:0];

        if (r3_spec) begin
            w_res = r3_sres;
            w_flg = r3_sflg;
        end else if (r3_sum == '0) begin
            w_res = '0;
            w_flg = 3'b000;
        end else if (w_flush) begin
            w_res = {r3_sign, {(N-1){1'b0}}};
            w_flg = 3'b001;
        end else if (w_e >= {1'b0, {EXP_W{1'b1}}}) begin
            w_res = {r3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flg = 3'b011;
        end else begin
            w_res = {r3_sign, w_e[EXP_W-1:0], w_frac};
            w_flg = {2'b00, |w_m[2:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_v      <= 1'b0;
            r2_v      <= 1'b0;
            r3_v      <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            flags     <= 3'b000;
        end else if (!w_stall) begin
            r1_v      <= in_valid;
            r2_v      <= r1_v;
            r3_v      <= r2_v;
            out_valid <= r3_v;
            if (r3_v) begin
                out   <= w_res;
                flags <= w_flg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r1_spec   <= w_spec;
            r1_sres   <= w_sres;
            r1_sflg   <= w_sflg;
            r1_sign   <= w_swap ? w_sb : w_sa;
            r1_esub   <= w_sa ^ w_sb;
            r1_exp    <= w_swap ? w_eb : w_ea;
            r1_d      <= w_swap ? (w_eb - w_ea) : (w_ea - w_eb);
            r1_frac_l <= w_swap ? w_fb : w_fa;
            r1_frac_s <= w_swap ? w_fa : w_fb;

            r2_spec   <= r1_spec;
            r2_sres   <= r1_sres;
            r2_sflg   <= r1_sflg;
            r2_sign   <= r1_sign;
            r2_esub   <= r1_esub;
            r2_exp    <= r1_exp;
            r2_man_l  <= {1'b1, r1_frac_l, 3'b000};
            r2_man_s  <= w_mal;

            r3_spec   <= r2_spec;
            r3_sres   <= r2_sres;
            r3_sflg   <= r2_sflg;
            r3_sign   <= r2_sign;
            r3_exp    <= r2_exp;
            r3_sum    <= w_sum;
            r3_lzc    <= w_lzc;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fadd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fadd_pipe
// Brief    : Directed-vector and handshake/stall/reset bench for fadd_pipe.
// Revision : 1.0
// ============================================================================
module tb_fadd_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv32, ir32, sub32, ov32, or32;
    logic [31:0] a32, b32, o32;
    logic [2:0]  f32;
    logic        iv64, ir64, sub64, ov64, or64;
    logic [63:0] a64, b64, o64;
    logic [2:0]  f64;

    fadd_pipe #(.N(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .sub(sub32), .out_valid(ov32), .out_ready(or32), .out(o32), .flags(f32)
    );
    fadd_pipe #(.N(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
        .sub(sub64), .out_valid(ov64), .out_ready(or64), .out(o64), .flags(f64)
    );

    typedef struct {
        bit          dbl;
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic [63:0] res;
        logic [2:0]  fl;
    } vec_t;

    localparam int NV  = 25;
    localparam int N32 = 22;
    vec_t tv [NV];

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] q_out [$];
    logic [2:0]  q_fl  [$];

    function automatic vec_t mk(input bit dbl, input logic [63:0] a, input logic [63:0] b,
                                input logic s, input logic [63:0] r, input logic [2:0] f);
        vec_t v;
        v.dbl = dbl; v.a = a; v.b = b; v.sub = s; v.res = r; v.fl = f;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic one_op(input vec_t v, output logic [63:0] res, output logic [2:0] fl,
                          output int lat);
        @(posedge clk); #1;
        if (v.dbl) begin a64 = v.a; b64 = v.b; sub64 = v.sub; iv64 = 1'b1; end
        else begin a32 = v.a[31:0]; b32 = v.b[31:0]; sub32 = v.sub; iv32 = 1'b1; end
        @(posedge clk); #1;
        iv32 = 1'b0;
        iv64 = 1'b0;
        lat  = 1;
        while (lat < 12) begin
            if (v.dbl ? ov64 : ov32) break;
            @(posedge clk); #1;
            lat++;
        end
        res = v.dbl ? o64 : {32'h0, o32};
        fl  = v.dbl ? f64 : f32;
    endtask

    // Streams nops operands from tv[base..] with random back-pressure.
    task automatic stream(input int base, input int nops, input bit drain);
        int          sent = 0;
        int          cyc  = 0;
        int          k;
        bit          held = 1'b0;
        logic [31:0] h_out = '0;
        logic [2:0]  h_fl  = '0;
        while ((sent < nops || (drain && q_out.size() > 0)) && cyc < 400) begin
            @(posedge clk); #1;
            if (held) begin
                check("hold_valid", 64'(ov32), 64'd1);
                check("hold_out",   64'(o32),  64'(h_out));
                check("hold_flags", 64'(f32),  64'(h_fl));
            end
            k     = (base + sent) % N32;
            iv32  = (sent < nops);
            a32   = tv[k].a[31:0];
            b32   = tv[k].b[31:0];
            sub32 = tv[k].sub;
            or32  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("in_ready", 64'(ir32), 64'(!(ov32 && !or32)));
            if (iv32 && ir32) begin
                q_out.push_back(tv[k].res[31:0]);
                q_fl.push_back(tv[k].fl);
                sent++;
            end
            if (ov32 && or32) begin
                if (q_out.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stream_extra: got %h expected no result", o32);
                end else begin
                    check("stream_out",   64'(o32), 64'(q_out.pop_front()));
                    check("stream_flags", 64'(f32), 64'(q_fl.pop_front()));
                end
            end
            held  = ov32 && !or32;
            h_out = o32;
            h_fl  = f32;
            cyc++;
        end
        if (cyc >= 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL stream_timeout: got %0d pending expected 0", q_out.size());
        end
        @(posedge clk); #1;
        iv32 = 1'b0;
    endtask

    initial begin
        logic [63:0] r;
        logic [2:0]  f;
        int          lat;

        tv[0]  = mk(0, 64'h3F800000, 64'h3F800000, 0, 64'h40000000, 3'b000);
        tv[1]  = mk(0, 64'h3F800000, 64'h3F800000, 1, 64'h00000000, 3'b000);
        tv[2]  = mk(0, 64'h80000000, 64'h00000000, 1, 64'h80000000, 3'b000);
        tv[3]  = mk(0, 64'h3F800000, 64'h33800000, 0, 64'h3F800000, 3'b001);
        tv[4]  = mk(0, 64'h3F800000, 64'h33800001, 0, 64'h3F800001, 3'b001);
        tv[5]  = mk(0, 64'h7F7FFFFF, 64'h7F7FFFFF, 0, 64'h7F800000, 3'b011);
        tv[6]  = mk(0, 64'h7F800000, 64'hFF800000, 0, 64'h7FC00000, 3'b100);
        tv[7]  = mk(0, 64'h7FC00001, 64'h3F800000, 0, 64'h7FC00000, 3'b000);
        tv[8]  = mk(0, 64'h7F800001, 64'h3F800000, 0, 64'h7FC00000, 3'b000);
        tv[9]  = mk(0, 64'h7F800000, 64'h3F800000, 0, 64'h7F800000, 3'b000);
        tv[10] = mk(0, 64'h3F800000, 64'h7F800000, 1, 64'hFF800000, 3'b000);
        tv[11] = mk(0, 64'h00000000, 64'h40400000, 0, 64'h40400000, 3'b000);
        tv[12] = mk(0, 64'h00000000, 64'h40400000, 1, 64'hC0400000, 3'b000);
        tv[13] = mk(0, 64'h00000001, 64'h3F800000, 0, 64'h3F800000, 3'b000);
        tv[14] = mk(0, 64'h3F800000, 64'hBF400000, 0, 64'h3E800000, 3'b000);
        tv[15] = mk(0, 64'h00C00000, 64'h00800000, 1, 64'h00000000, 3'b001);
        tv[16] = mk(0, 64'h3F800001, 64'h33800000, 0, 64'h3F800002, 3'b001);
        tv[17] = mk(0, 64'h3F800000, 64'h00800000, 0, 64'h3F800000, 3'b001);
        tv[18] = mk(0, 64'h7F7FFFFF, 64'h73000000, 0, 64'h7F800000, 3'b011);
        tv[19] = mk(0, 64'h3F800000, 64'h40000000, 1, 64'hBF800000, 3'b000);
        tv[20] = mk(0, 64'h80000000, 64'h80000000, 0, 64'h80000000, 3'b000);
        tv[21] = mk(0, 64'h00000000, 64'h80000000, 0, 64'h00000000, 3'b000);
        tv[22] = mk(1, 64'h3FF0000000000000, 64'h4000000000000000, 0, 64'h4008000000000000, 3'b000);
        tv[23] = mk(1, 64'h3FF0000000000000, 64'h3FF0000000000000, 1, 64'h0000000000000000, 3'b000);
        tv[24] = mk(1, 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 0, 64'h7FF0000000000000, 3'b011);

        rst_n = 1'b0;
        iv32 = 1'b0; a32 = '0; b32 = '0; sub32 = 1'b0; or32 = 1'b1;
        iv64 = 1'b0; a64 = '0; b64 = '0; sub64 = 1'b0; or64 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid32", 64'(ov32), 64'd0);
        check("rst_out32",   64'(o32),  64'd0);
        check("rst_flags32", 64'(f32),  64'd0);
        check("rst_ready32", 64'(ir32), 64'd1);
        check("rst_valid64", 64'(ov64), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            one_op(tv[i], r, f, lat);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
            check($sformatf("v%0d_out", i),     r,        tv[i].res);
            check($sformatf("v%0d_flags", i),   64'(f),   64'(tv[i].fl));
        end

        stream(0, 5, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(ov32), 64'd0);
        check("midrst_out",   64'(o32),  64'd0);
        check("midrst_flags", 64'(f32),  64'd0);
        q_out.delete();
        q_fl.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        or32  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_valid", 64'(ov32), 64'd0);
        end

        stream(5, 5, 1'b1);
        or32 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("drained_valid", 64'(ov32), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
